commit_sequencer: RTL and testbench

// - Takes the ROB head entry, classifies it by commit type (RV64IM + Zicsr + system ops), and sequences its retirement.
// - Retirement is handshaked with the int RF, store buffer and CSR unit; FENCE drain, WFI stall and trap/MRET flushes are handled.
// - Sits between the ROB head and the architectural-state owners; one instruction per commit.

---
 rtl/commit_sequencer.sv | 216 +++++++++++++++++++++
 tb/tb_commit_sequencer.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/commit_sequencer.sv
// Commit sequencer: classifies the ROB head entry and sequences its retirement
// through the RF / store buffer / CSR handshakes. Optional instret counter: LEN5_COMMIT_PERF_EN.
module commit_sequencer #(
  parameter int unsigned XLEN      = 64,
  parameter int unsigned ILEN      = 32,
  parameter int unsigned ROB_IDX_W = 6,
  parameter int unsigned EXC_W     = 5
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 rob_valid_i,
  output logic                 rob_ready_o,
  input  logic [ILEN-1:0]      rob_instr_i,
  input  logic [ROB_IDX_W-1:0] rob_idx_i,
  input  logic                 rob_except_i,
  input  logic [EXC_W-1:0]     rob_exc_code_i,
  output logic                 rf_valid_o,
  input  logic                 rf_ready_i,
  output logic                 sb_valid_o,
  input  logic                 sb_ready_i,
  input  logic                 sb_empty_i,
  output logic                 csr_valid_o,
  input  logic                 csr_ready_i,
  input  logic                 irq_pending_i,
  output logic [ROB_IDX_W-1:0] comm_idx_o,
  output logic                 retire_o,
  output logic                 flush_o,
  output logic                 trap_o,
  output logic                 mret_o,
  output logic [EXC_W-1:0]     exc_code_o
`ifdef LEN5_COMMIT_PERF_EN
  ,
  input  logic                 instret_clr_i,
  output logic [XLEN-1:0]      instret_o
`endif
);

  if (ILEN != 32 || XLEN < 32) begin : g_bad_cfg
    $error("commit_sequencer: unsupported ILEN/XLEN");
  end

  typedef enum logic [2:0] {
    CT_INT, CT_STORE, CT_BRANCH, CT_CSR, CT_EXCEPT, CT_MRET, CT_WFI, CT_FENCE
  } ctype_e;

  typedef enum logic [2:0] {
    S_IDLE, S_COMMIT, S_DRAIN, S_WFI, S_FLUSH
  } state_e;

  state_e               state_q;
  ctype_e               type_q;
  logic [ROB_IDX_W-1:0] idx_q;
  logic                 rf_valid_q, sb_valid_q, csr_valid_q;
  logic                 flush_q, trap_q, mret_q;
  logic [EXC_W-1:0]     exc_q;

  ctype_e               dec_type;
  logic [EXC_W-1:0]     dec_code;
  logic                 retire_now;

  logic [6:0] opc, f7;
  logic [2:0] f3;
  assign opc = rob_instr_i[6:0];
  assign f3  = rob_instr_i[14:12];
  assign f7  = rob_instr_i[31:25];

  // Anything not explicitly recognised below falls through as an illegal instruction.
  always_comb begin
    dec_type = CT_EXCEPT;
    dec_code = EXC_W'(2);
    case (opc)
      7'b0110011:
        if (f7 == 7'h00 || f7 == 7'h01 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)))
          dec_type = CT_INT;
      7'b0111011:
        if ((f7 == 7'h00 && (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd5)) ||
            (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)) ||
            (f7 == 7'h01 && f3 != 3'd1 && f3 != 3'd2 && f3 != 3'd3))
          dec_type = CT_INT;
      7'b0010011:
        if (f3 == 3'd1) begin
          if (rob_instr_i[31:26] == 6'b000000) dec_type = CT_INT;
        end else if (f3 == 3'd5) begin
          if (rob_instr_i[31:26] == 6'b000000 || rob_instr_i[31:26] == 6'b010000) dec_type = CT_INT;
        end else begin
          dec_type = CT_INT;
        end
      7'b0011011:
        if (f3 == 3'd0 || (f3 == 3'd1 && f7 == 7'h00) ||
            (f3 == 3'd5 && (f7 == 7'h00 || f7 == 7'h20)))
          dec_type = CT_INT;
      7'b0110111, 7'b0010111, 7'b1101111: dec_type = CT_INT;
      7'b1100111: if (f3 == 3'd0) dec_type = CT_INT;
      7'b0000011: if (f3 != 3'd7) dec_type = CT_INT;
      7'b0100011: if (!f3[2]) dec_type = CT_STORE;
      7'b1100011: if (f3 != 3'd2 && f3 != 3'd3) dec_type = CT_BRANCH;
      7'b0001111: if (f3 == 3'd0) dec_type = CT_FENCE;
      7'b1110011:
        if (f3 != 3'd0 && f3 != 3'd4) begin
          dec_type = CT_CSR;
        end else if (rob_instr_i == 32'h0000_0073) begin
          dec_code = EXC_W'(11);
        end else if (rob_instr_i == 32'h0010_0073) begin
          dec_code = EXC_W'(3);
        end else if (rob_instr_i == 32'h3020_0073) begin
          dec_type = CT_MRET;
        end else if (rob_instr_i == 32'h1050_0073) begin
          dec_type = CT_WFI;
        end
      default: ;
    endcase
    if (rob_except_i) begin
      dec_type = CT_EXCEPT;
      dec_code = rob_exc_code_i;
    end
  end

  // Retirement is taken in the same cycle the awaited condition is observed.
  always_comb begin
    retire_now = 1'b0;
    case (state_q)
      S_COMMIT:
        case (type_q)
          CT_INT:    retire_now = rf_ready_i;
          CT_STORE:  retire_now = sb_ready_i;
          CT_CSR:    retire_now = csr_ready_i;
          CT_BRANCH: retire_now = 1'b1;
          default:   retire_now = 1'b0;
        endcase
      S_DRAIN: retire_now = sb_empty_i;
      S_WFI:   retire_now = irq_pending_i;
      S_FLUSH: retire_now = mret_q;
      default: retire_now = 1'b0;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= S_IDLE;
      type_q      <= CT_INT;
      idx_q       <= '0;
      rf_valid_q  <= 1'b0;
      sb_valid_q  <= 1'b0;
      csr_valid_q <= 1'b0;
      flush_q     <= 1'b0;
      trap_q      <= 1'b0;
      mret_q      <= 1'b0;
      exc_q       <= '0;
    end else begin
      flush_q <= 1'b0;
      trap_q  <= 1'b0;
      mret_q  <= 1'b0;
      exc_q   <= '0;
      case (state_q)
        S_IDLE:
          if (rob_valid_i) begin
            type_q <= dec_type;
            idx_q  <= rob_idx_i;
            case (dec_type)
              CT_INT:    begin rf_valid_q  <= 1'b1; state_q <= S_COMMIT; end
              CT_STORE:  begin sb_valid_q  <= 1'b1; state_q <= S_COMMIT; end
              CT_CSR:    begin csr_valid_q <= 1'b1; state_q <= S_COMMIT; end
              CT_BRANCH: state_q <= S_COMMIT;
              CT_FENCE:  state_q <= S_DRAIN;
              CT_WFI:    state_q <= S_WFI;
              CT_MRET:   begin flush_q <= 1'b1; mret_q <= 1'b1; state_q <= S_FLUSH; end
              default:   begin
                flush_q <= 1'b1;
                trap_q  <= 1'b1;
                exc_q   <= dec_code;
                state_q <= S_FLUSH;
              end
            endcase
          end
        S_COMMIT:
          if (retire_now) begin
            rf_valid_q  <= 1'b0;
            sb_valid_q  <= 1'b0;
            csr_valid_q <= 1'b0;
            if (type_q == CT_CSR) begin
              flush_q <= 1'b1;
              state_q <= S_FLUSH;
            end else begin
              state_q <= S_IDLE;
            end
          end
        S_DRAIN, S_WFI: if (retire_now) state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign rob_ready_o = (state_q == S_IDLE);
  assign rf_valid_o  = rf_valid_q;
  assign sb_valid_o  = sb_valid_q;
  assign csr_valid_o = csr_valid_q;
  assign comm_idx_o  = idx_q;
  assign retire_o    = retire_now;
  assign flush_o     = flush_q;
  assign trap_o      = trap_q;
  assign mret_o      = mret_q;
  assign exc_code_o  = exc_q;

`ifdef LEN5_COMMIT_PERF_EN
  logic [XLEN-1:0] instret_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)           instret_q <= '0;
    else if (instret_clr_i) instret_q <= '0;
    else if (retire_now)    instret_q <= instret_q + XLEN'(1);
  end

  assign instret_o = instret_q;
`endif

endmodule

// File: tb/tb_commit_sequencer.sv
// Randomized bench for commit_sequencer: each ROB head transaction is scored
// against the expected per-cycle handshake sequence for its commit class.
module tb_commit_sequencer;
  localparam int unsigned XLEN = 64, ILEN = 32, ROB_IDX_W = 6, EXC_W = 5;

  logic                 clk_i = 1'b0;
  logic                 rst_n_i;
  logic                 rob_valid_i, rob_ready_o;
  logic [ILEN-1:0]      rob_instr_i;
  logic [ROB_IDX_W-1:0] rob_idx_i;
  logic                 rob_except_i;
  logic [EXC_W-1:0]     rob_exc_code_i;
  logic                 rf_valid_o, rf_ready_i;
  logic                 sb_valid_o, sb_ready_i, sb_empty_i;
  logic                 csr_valid_o, csr_ready_i, irq_pending_i;
  logic [ROB_IDX_W-1:0] comm_idx_o;
  logic                 retire_o, flush_o, trap_o, mret_o;
  logic [EXC_W-1:0]     exc_code_o;
`ifdef LEN5_COMMIT_PERF_EN
  logic                 instret_clr_i;
  logic [XLEN-1:0]      instret_o;
`endif

  always #5 clk_i = ~clk_i;

  commit_sequencer #(.XLEN(XLEN), .ILEN(ILEN), .ROB_IDX_W(ROB_IDX_W), .EXC_W(EXC_W)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i),
    .rob_valid_i(rob_valid_i), .rob_ready_o(rob_ready_o), .rob_instr_i(rob_instr_i),
    .rob_idx_i(rob_idx_i), .rob_except_i(rob_except_i), .rob_exc_code_i(rob_exc_code_i),
    .rf_valid_o(rf_valid_o), .rf_ready_i(rf_ready_i),
    .sb_valid_o(sb_valid_o), .sb_ready_i(sb_ready_i), .sb_empty_i(sb_empty_i),
    .csr_valid_o(csr_valid_o), .csr_ready_i(csr_ready_i), .irq_pending_i(irq_pending_i),
    .comm_idx_o(comm_idx_o), .retire_o(retire_o), .flush_o(flush_o), .trap_o(trap_o),
    .mret_o(mret_o), .exc_code_o(exc_code_o)
`ifdef LEN5_COMMIT_PERF_EN
    , .instret_clr_i(instret_clr_i), .instret_o(instret_o)
`endif
  );

  typedef enum int {K_INT, K_STORE, K_BRANCH, K_CSR, K_FENCE, K_WFI, K_EXC, K_MRET} kind_e;

  int unsigned     n_vec = 0, n_err = 0;
  longint unsigned exp_instret = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] outs();
    return {rob_ready_o, rf_valid_o, sb_valid_o, csr_valid_o, retire_o, flush_o, trap_o, mret_o};
  endfunction

  function automatic logic [7:0] ev(bit rdy, bit rf, bit sb, bit csr, bit ret, bit fl, bit tr, bit mr);
    return {rdy, rf, sb, csr, ret, fl, tr, mr};
  endfunction

  // Reference instret: clear wins over a retirement in the same cycle.
  task automatic tick(input bit ret);
`ifdef LEN5_COMMIT_PERF_EN
    if (instret_clr_i) exp_instret = 0;
    else if (ret)      exp_instret = exp_instret + 1;
`else
    if (ret) exp_instret = exp_instret + 1;
`endif
  endtask

  task automatic noise();
    rob_valid_i    = 1'($urandom);
    rob_instr_i    = $urandom;
    rob_idx_i      = ROB_IDX_W'($urandom);
    rob_except_i   = 1'($urandom);
    rob_exc_code_i = EXC_W'($urandom);
    rf_ready_i     = 1'($urandom);
    sb_ready_i     = 1'($urandom);
    csr_ready_i    = 1'($urandom);
    sb_empty_i     = 1'($urandom);
    irq_pending_i  = 1'($urandom);
`ifdef LEN5_COMMIT_PERF_EN
    instret_clr_i  = ($urandom_range(0, 7) == 0);
`endif
  endtask

  function automatic logic [31:0] enc(logic [6:0] f7, logic [2:0] f3, logic [6:0] opc);
    logic [4:0] rs2, rs1, rd;
    rs2 = 5'($urandom); rs1 = 5'($urandom); rd = 5'($urandom);
    return {f7, rs2, rs1, f3, rd, opc};
  endfunction

  // Builds a random instruction of the requested class; cause is the expected trap code.
  task automatic gen(input kind_e k, output logic [31:0] instr, output logic [4:0] cause);
    logic [2:0] br_f3 [6];
    logic [2:0] csr_f3 [6];
    logic [2:0] imm_f3 [6];
    logic [6:0] r7;
    br_f3  = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};
    csr_f3 = '{3'd1, 3'd2, 3'd3, 3'd5, 3'd6, 3'd7};
    imm_f3 = '{3'd0, 3'd2, 3'd3, 3'd4, 3'd6, 3'd7};
    r7 = 7'($urandom);
    cause = 5'd0;
    case (k)
      K_INT:
        case ($urandom_range(0, 9))
          0: instr = enc(7'h00, 3'($urandom), 7'b0110011);
          1: instr = enc(7'h01, 3'($urandom), 7'b0110011);
          2: instr = enc(7'h20, 3'd0, 7'b0110011);
          3: instr = {25'($urandom), 7'b0110111};
          4: instr = {25'($urandom), 7'b0010111};
          5: instr = {25'($urandom), 7'b1101111};
          6: instr = enc(r7, 3'd0, 7'b1100111);
          7: instr = enc(r7, 3'($urandom_range(0, 6)), 7'b0000011);
          8: instr = enc(r7, imm_f3[$urandom_range(0, 5)], 7'b0010011);
          default: instr = enc(r7, 3'd0, 7'b0011011);
        endcase
      K_STORE:  instr = enc(r7, 3'($urandom_range(0, 3)), 7'b0100011);
      K_BRANCH: instr = enc(r7, br_f3[$urandom_range(0, 5)], 7'b1100011);
      K_CSR:    instr = enc(r7, csr_f3[$urandom_range(0, 5)], 7'b1110011);
      K_FENCE:  instr = enc(r7, 3'd0, 7'b0001111);
      K_WFI:    instr = 32'h1050_0073;
      K_MRET:   instr = 32'h3020_0073;
      default:
        case ($urandom_range(0, 4))
          0: begin instr = 32'h0000_0073; cause = 5'd11; end
          1: begin instr = 32'h0010_0073; cause = 5'd3; end
          2: begin instr = 32'h0000_0000; cause = 5'd2; end
          3: begin instr = 32'hFFFF_FFFF; cause = 5'd2; end
          default: begin instr = enc(r7, 3'd7, 7'b0000011); cause = 5'd2; end
        endcase
    endcase
  endtask

  // Entered and left at a falling edge with the DUT idle.
  task automatic run_txn(input kind_e k, input logic [31:0] instr, input bit exc,
                         input logic [4:0] cause, input int unsigned d);
    logic [ROB_IDX_W-1:0] idx;
    kind_e ek;
    idx = ROB_IDX_W'($urandom);
    ek  = exc ? K_EXC : k;
    noise();
    rob_valid_i = 1'b1; rob_instr_i = instr; rob_idx_i = idx; rob_except_i = exc;
    if (exc) rob_exc_code_i = cause;
    #1 check_eq("idle_outs", 64'(outs()), 64'(ev(1,0,0,0,0,0,0,0)));
`ifdef LEN5_COMMIT_PERF_EN
    check_eq("instret", instret_o, exp_instret);
`endif
    tick(0);
    @(negedge clk_i);
    case (ek)
      K_INT, K_STORE, K_CSR: begin
        for (int unsigned c = 0; c <= d; c++) begin
          noise();
          if (ek == K_INT)   rf_ready_i  = (c == d);
          if (ek == K_STORE) sb_ready_i  = (c == d);
          if (ek == K_CSR)   csr_ready_i = (c == d);
          #1 check_eq("commit_outs", 64'(outs()),
                      64'(ev(0, ek == K_INT, ek == K_STORE, ek == K_CSR, c == d, 0, 0, 0)));
          check_eq("comm_idx", 64'(comm_idx_o), 64'(idx));
          tick(c == d);
          @(negedge clk_i);
        end
        if (ek == K_CSR) begin
          noise();
          #1 check_eq("csr_resync", 64'(outs()), 64'(ev(0,0,0,0,0,1,0,0)));
          tick(0);
          @(negedge clk_i);
        end
      end
      K_FENCE, K_WFI: begin
        for (int unsigned c = 0; c <= d; c++) begin
          noise();
          if (ek == K_FENCE) sb_empty_i    = (c == d);
          else               irq_pending_i = (c == d);
          #1 check_eq(ek == K_FENCE ? "drain_outs" : "wfi_outs", 64'(outs()),
                      64'(ev(0,0,0,0, c == d, 0,0,0)));
          tick(c == d);
          @(negedge clk_i);
        end
      end
      K_BRANCH: begin
        noise();
        #1 check_eq("branch_outs", 64'(outs()), 64'(ev(0,0,0,0,1,0,0,0)));
        tick(1);
        @(negedge clk_i);
      end
      K_MRET: begin
        noise();
        #1 check_eq("mret_outs", 64'(outs()), 64'(ev(0,0,0,0,1,1,0,1)));
        tick(1);
        @(negedge clk_i);
      end
      default: begin
        noise();
        #1 check_eq("trap_outs", 64'(outs()), 64'(ev(0,0,0,0,0,1,1,0)));
        check_eq("exc_code", 64'(exc_code_o), 64'(cause));
        tick(0);
        @(negedge clk_i);
      end
    endcase
  endtask

  // WFI interrupted by reset: no retire, outputs return to the reset state at once.
  task automatic run_wfi_reset();
    run_txn(K_WFI, 32'h1050_0073, 0, 5'd0, 3);
    noise();
    rob_valid_i = 1'b1; rob_instr_i = 32'h1050_0073; rob_except_i = 1'b0;
    #1 check_eq("idle_outs", 64'(outs()), 64'(ev(1,0,0,0,0,0,0,0)));
    tick(0);
    @(negedge clk_i);
    for (int unsigned c = 0; c < 4; c++) begin
      noise();
      irq_pending_i = 1'b0;
      #1 check_eq("wfi_wait", 64'(outs()), 64'(ev(0,0,0,0,0,0,0,0)));
      tick(0);
      @(negedge clk_i);
    end
    noise();
    rob_valid_i = 1'b0; irq_pending_i = 1'b1;
    rst_n_i = 1'b0;
    #1 check_eq("reset_mid_wfi", 64'(outs()), 64'(ev(1,0,0,0,0,0,0,0)));
    check_eq("reset_exc_code", 64'(exc_code_o), 64'd0);
    exp_instret = 0;
    @(negedge clk_i);
    rst_n_i = 1'b1;
  endtask

  initial begin
    logic [31:0] instr;
    logic [4:0]  cause;
    kind_e       k;
    bit          exc;

    rst_n_i = 1'b0;
    rob_valid_i = 0; rob_instr_i = '0; rob_idx_i = '0; rob_except_i = 0; rob_exc_code_i = '0;
    rf_ready_i = 0; sb_ready_i = 0; sb_empty_i = 0; csr_ready_i = 0; irq_pending_i = 0;
`ifdef LEN5_COMMIT_PERF_EN
    instret_clr_i = 0;
`endif
    repeat (2) @(negedge clk_i);
    #1 check_eq("reset_outs", 64'(outs()), 64'(ev(1,0,0,0,0,0,0,0)));
    check_eq("reset_idx", 64'(comm_idx_o), 64'd0);
    check_eq("reset_exc_code", 64'(exc_code_o), 64'd0);
    @(negedge clk_i);
    rst_n_i = 1'b1;
    @(negedge clk_i);

    run_txn(K_INT, enc(7'h00, 3'd0, 7'b0110011), 0, 5'd0, 3);
    run_txn(K_STORE, enc(7'h00, 3'd3, 7'b0100011), 0, 5'd0, 1);
    run_txn(K_FENCE, 32'h0FF0_000F, 0, 5'd0, 4);
    run_txn(K_EXC, 32'h0000_0073, 0, 5'd11, 0);
    run_txn(K_EXC, 32'h0000_0000, 0, 5'd2, 0);
    run_txn(K_INT, enc(7'h00, 3'd2, 7'b0000011), 1, 5'd5, 2);
    run_txn(K_CSR, enc(7'h05, 3'd1, 7'b1110011), 0, 5'd0, 2);
    run_txn(K_MRET, 32'h3020_0073, 0, 5'd0, 0);
    run_txn(K_BRANCH, enc(7'h00, 3'd0, 7'b1100011), 0, 5'd0, 0);
    run_txn(K_FENCE, 32'h0330_000F, 0, 5'd0, 0);
    run_txn(K_WFI, 32'h1050_0073, 0, 5'd0, 10);
    run_wfi_reset();

    for (int unsigned t = 0; t < 400; t++) begin
      k   = kind_e'($urandom_range(0, 7));
      exc = ($urandom_range(0, 7) == 0);
      gen(k, instr, cause);
      if (exc) cause = 5'($urandom);
      run_txn(k, instr, exc, cause, $urandom_range(0, 5));
    end

    noise();
    rob_valid_i = 1'b0;
    #1 check_eq("final_idle", 64'(outs()), 64'(ev(1,0,0,0,0,0,0,0)));
`ifdef LEN5_COMMIT_PERF_EN
    check_eq("final_instret", instret_o, exp_instret);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
